// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: rotates the search start past the last winner and holds
// a registered one-hot grant until done, request drop or hold timeout.
module round_robin_arbiter #(
   parameter int N        = 8,
   parameter int ID_W     = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            busy,
   output logic            timeout
);
   localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [ID_W-1:0] last_id;
   logic [HC_W-1:0] hold_cnt;
   logic [ID_W-1:0] win;
   logic [ID_W-1:0] idx;
   logic            found;
   logic            tmo_hit;
   logic            rel;

   // Scan last_id+1 .. last_id+N modulo N; modulo keeps non-power-of-two N correct.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = ID_W'((int'(last_id) + k) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign tmo_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   assign rel     = done || !req[gnt_id] || tmo_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         last_id  <= ID_W'(N - 1);
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (found) begin
                  state    <= GRANT;
                  gnt      <= N'(1) << win;
                  gnt_id   <= win;
                  busy     <= 1'b1;
                  last_id  <= win;
                  hold_cnt <= '0;
               end else begin
                  gnt  <= '0;
                  busy <= 1'b0;
               end
            end
            GRANT: begin
               if (rel) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  // done and request drop win over the timeout flag
                  timeout <= tmo_hit && !done && req[gnt_id];
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: one timed-out instance and one with
// MAX_HOLD=0, checked against hand-computed grant sequences.
module tb_round_robin_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0, req0 = '0;
   logic       done = 1'b0, done0 = 1'b0;
   logic [7:0] gnt, gnt0;
   logic [2:0] gnt_id, gnt_id0;
   logic       busy, busy0, timeout, timeout0;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   round_robin_arbiter #(.N(8), .ID_W(3), .MAX_HOLD(16)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout));

   round_robin_arbiter #(.N(8), .ID_W(3), .MAX_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .done(done0),
      .gnt(gnt0), .gnt_id(gnt_id0), .busy(busy0), .timeout(timeout0));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      n_chk++;
      if ({gnt, gnt_id, busy, timeout} !== 13'h0) begin
         n_err++;
         $display("FAIL reset: got gnt=%h id=%0d busy=%b to=%b, want all 0", gnt, gnt_id, busy, timeout);
      end
      n_chk++;
      if ({gnt0, busy0, timeout0} !== 10'h0) begin
         n_err++;
         $display("FAIL reset0: got gnt=%h busy=%b to=%b, want all 0", gnt0, busy0, timeout0);
      end
      rst = 1'b0;
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      req  = 8'hFF;
      done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_g = 8'h01 << (i % 8);
         step();
         n_chk++;
         if ({gnt, gnt_id, busy} !== {exp_g, 3'(i % 8), 1'b1}) begin
            n_err++;
            $display("FAIL rotation grant %0d: got gnt=%h id=%0d busy=%b, want gnt=%h id=%0d busy=1",
                     i, gnt, gnt_id, busy, exp_g, i % 8);
         end
         step();
         n_chk++;
         if ({gnt, busy, timeout} !== 10'h0) begin
            n_err++;
            $display("FAIL rotation idle %0d: got gnt=%h busy=%b to=%b, want 0", i, gnt, busy, timeout);
         end
      end
      req  = 8'h00;
      done = 1'b0;
   endtask

   task automatic test_timeout();
      req = 8'h10;
      for (int c = 0; c < 16; c++) begin
         step();
         n_chk++;
         if ({gnt, gnt_id, timeout} !== {8'h10, 3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL timeout hold cyc %0d: got gnt=%h id=%0d to=%b, want gnt=10 id=4 to=0",
                     c, gnt, gnt_id, timeout);
         end
      end
      step();
      n_chk++;
      if ({gnt, busy, timeout, gnt_id} !== {8'h00, 1'b0, 1'b1, 3'd4}) begin
         n_err++;
         $display("FAIL timeout pulse: got gnt=%h busy=%b to=%b id=%0d, want gnt=0 busy=0 to=1 id=4",
                  gnt, busy, timeout, gnt_id);
      end
      step();
      n_chk++;
      if ({gnt, gnt_id, timeout} !== {8'h10, 3'd4, 1'b0}) begin
         n_err++;
         $display("FAIL timeout regrant: got gnt=%h id=%0d to=%b, want gnt=10 id=4 to=0", gnt, gnt_id, timeout);
      end
      req = 8'h00;
      step();
      n_chk++;
      if ({gnt, timeout} !== 9'h0) begin
         n_err++;
         $display("FAIL timeout drop: got gnt=%h to=%b, want 0", gnt, timeout);
      end
   endtask

   task automatic test_req_drop();
      // Park last_id at 0
      req  = 8'h01;
      done = 1'b1;
      step();
      req  = 8'h00;
      done = 1'b0;
      step();
      req = 8'h05;
      step();
      n_chk++;
      if ({gnt, gnt_id} !== {8'h04, 3'd2}) begin
         n_err++;
         $display("FAIL drop first: got gnt=%h id=%0d, want gnt=04 id=2", gnt, gnt_id);
      end
      step();
      step();
      n_chk++;
      if (gnt !== 8'h04) begin
         n_err++;
         $display("FAIL drop hold: got gnt=%h, want 04", gnt);
      end
      req = 8'h01;
      step();
      n_chk++;
      if ({gnt, busy, timeout} !== 10'h0) begin
         n_err++;
         $display("FAIL drop release: got gnt=%h busy=%b to=%b, want 0", gnt, busy, timeout);
      end
      step();
      n_chk++;
      if ({gnt, gnt_id} !== {8'h01, 3'd0}) begin
         n_err++;
         $display("FAIL drop next: got gnt=%h id=%0d, want gnt=01 id=0", gnt, gnt_id);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_precedence();
      req = 8'h08;
      step();
      for (int c = 1; c <= 15; c++) begin
         req = (c % 2 == 1) ? 8'h89 : 8'h08;
         step();
         n_chk++;
         if ({gnt, gnt_id} !== {8'h08, 3'd3}) begin
            n_err++;
            $display("FAIL precedence hold cyc %0d: got gnt=%h id=%0d, want gnt=08 id=3", c, gnt, gnt_id);
         end
      end
      req  = 8'h08;
      done = 1'b1;
      step();
      n_chk++;
      if ({gnt, busy, timeout} !== 10'h0) begin
         n_err++;
         $display("FAIL precedence release: got gnt=%h busy=%b to=%b, want gnt=0 busy=0 to=0", gnt, busy, timeout);
      end
      req  = 8'h00;
      done = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_grant();
      req = 8'h20;
      step();
      n_chk++;
      if ({gnt, gnt_id} !== {8'h20, 3'd5}) begin
         n_err++;
         $display("FAIL midrst grant: got gnt=%h id=%0d, want gnt=20 id=5", gnt, gnt_id);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({gnt, gnt_id, busy} !== 12'h0) begin
         n_err++;
         $display("FAIL midrst async: got gnt=%h id=%0d busy=%b, want all 0", gnt, gnt_id, busy);
      end
      step();
      req = 8'h81;
      rst = 1'b0;
      step();
      n_chk++;
      if ({gnt, gnt_id} !== {8'h01, 3'd0}) begin
         n_err++;
         $display("FAIL midrst restart: got gnt=%h id=%0d, want gnt=01 id=0", gnt, gnt_id);
      end
      done = 1'b1;
      step();
      req  = 8'h80;
      done = 1'b0;
      step();
      n_chk++;
      if ({gnt, gnt_id} !== {8'h80, 3'd7}) begin
         n_err++;
         $display("FAIL midrst top: got gnt=%h id=%0d, want gnt=80 id=7", gnt, gnt_id);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_no_timeout();
      int bad = 0;
      req0 = 8'h02;
      for (int c = 0; c < 100; c++) begin
         step();
         n_chk++;
         if ({gnt0, timeout0} !== {8'h02, 1'b0}) begin
            n_err++;
            bad++;
            if (bad < 4)
               $display("FAIL nohold cyc %0d: got gnt=%h to=%b, want gnt=02 to=0", c, gnt0, timeout0);
         end
      end
      done0 = 1'b1;
      step();
      n_chk++;
      if ({gnt0, busy0, timeout0} !== 10'h0) begin
         n_err++;
         $display("FAIL nohold done: got gnt=%h busy=%b to=%b, want 0", gnt0, busy0, timeout0);
      end
      req0  = 8'h00;
      done0 = 1'b0;
      step();
   endtask

   initial begin
      #3;
      test_reset();
      test_rotation();
      test_timeout();
      test_req_drop();
      test_precedence();
      test_reset_mid_grant();
      test_no_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Shares one resource among N requesters using rotating (round-robin) priority.
- Companion to the 8-input priority encoder. The encoder's fixed highest-bit-wins selection starves low-index inputs; this block rotates the search start past the last winner instead.
- Issues a registered one-hot grant plus a binary grant index.
- Holds the grant until the master signals done, drops its request, or exceeds a hold timeout.

Parameters:
- N, 8, number of requesters (2..16).
- ID_W, 3, width of gnt_id; must equal ceil(log2(N)).
- MAX_HOLD, 16, maximum cycles a grant may stay asserted; 0 disables the timeout.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- done  input  1  granted master releases the resource; sampled only while granted.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the granted requester; valid when busy=1.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, gnt_id=0, busy=0, timeout=0.
  - state=IDLE, hold_cnt=0, last_id=N-1, so the first search starts at index 0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit scanning last_id+1, last_id+2, ... with wrap modulo N.
  - Next edge: state=GRANT, gnt=one-hot(winner), gnt_id=winner, busy=1, last_id=winner, hold_cnt=0.
  - If req == 0, remain in IDLE with outputs 0.
  - done is ignored in IDLE.
- Latency: a request sampled in IDLE yields gnt on the following edge (1 cycle).
- GRANT:
  - hold_cnt increments each cycle; hold_cnt = number of gnt-high cycles minus 1.
  - Release conditions, evaluated each cycle:
    - (a) done=1;
    - (b) req[gnt_id]=0;
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release, next edge: gnt=0, busy=0, state=IDLE, gnt_id holds its last value.
  - timeout=1 for exactly that one cycle, only if (c) held and neither (a) nor (b) held. done and req-drop take precedence over timeout.
  - Changes to other req bits during GRANT are ignored; no preemption.
- Dead cycle: after any release the block spends at least one cycle in IDLE with gnt=0. The next arbitration uses req sampled in that cycle, so the minimum gap between grants is 1 cycle.
- Fairness: a requester held continuously high is granted within N grants.
- MAX_HOLD=0: a grant ends only via done or req-drop; hold_cnt saturates and never wraps.
- gnt is always zero or one-hot; never multi-hot or X after reset.
- Width rules:
  - hold_cnt is wide enough for MAX_HOLD-1.
  - last_id+1 wraps to 0 at N-1, for non-power-of-two N as well.

Test Plan:
1. Rotation: reset, then req=8'hFF held, done=1 in every grant's first cycle. Required gnt sequence: 01,02,04,08,10,20,40,80,01, with gnt_id 0..7,0. Each grant lasts 1 cycle with 1 idle cycle between grants.
2. Timeout (MAX_HOLD=16): req=8'h10 held, done=0. Required:
   - gnt=8'h10 for exactly 16 cycles;
   - the next cycle has gnt=0 and timeout=1;
   - the cycle after has gnt=8'h10 again, with gnt_id=4.
3. Request drop: with last_id=0, req=8'h05 gives gnt=8'h04. Drop req[2] after 3 grant cycles. Required: gnt=0 the next edge, timeout=0, then gnt=8'h01 after the idle cycle.
4. Precedence: done=1 in the same cycle hold_cnt==15. Required: release with timeout=0. Also: req bits 0/7 toggling during a grant to requester 3 leave gnt=8'h08 unchanged.
5. Reset mid-grant: assert rst while gnt=8'h20. Required:
   - gnt, busy, gnt_id clear without waiting for a clock edge;
   - after release, req=8'h81 gives gnt=8'h01 (search restarts at 0);
   - req=8'h80 alone gives gnt=8'h80.
6. No timeout (MAX_HOLD=0): req=8'h02 held, done=0 for 100 cycles. Required: gnt=8'h02 throughout and timeout never asserted. Then done=1 gives gnt=0 on the next edge.
